cdb_arbiter: RTL and testbench
==============================

Name: cdb_arbiter

Overview:
- Shares the single common data bus (CDB) between result producers: ALU (source 0) and load/store buffer (source 1).
- Each source pushes results into a private FIFO.
- A round-robin arbiter pops one result per cycle and drives a registered CDB broadcast.
- Reservation stations, ROB and register file snoop the broadcast, so they see at most one tag per cycle.

Parameters:
- NUM_SRC, 2, number of requesting units; index 0 = ALU, 1 = LSB, others appended.
- ENTRY_W, 5, ROB tag width; must match the shared ENTRY_RANGE constant.
- FIFO_DEPTH, 2, per-source queue depth; power of two, >= 1.

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  reset, asynchronous, active-low.
- rdy_in  input  1  global ready; low pauses the block.
- roll_back  input  1  misprediction flush.
- req_valid  input  NUM_SRC  per-source result valid.
- req_ready  output  NUM_SRC  per-source accept.
- req_entry  input  NUM_SRC*ENTRY_W  ROB tags, source i at [i*ENTRY_W +: ENTRY_W].
- req_value  input  NUM_SRC*32  result values.
- req_pc  input  NUM_SRC*32  result/target PCs.
- cdb_valid  output  1  broadcast strobe.
- cdb_entry  output  ENTRY_W  broadcast tag.
- cdb_value  output  32  broadcast value.
- cdb_pc  output  32  broadcast PC.
- cdb_src  output  clog2(NUM_SRC) (min 1)  granted source index.

Behaviour:
- Reset (rst_in low, any time, asynchronous):
  - all FIFOs empty; rr_ptr = 0.
  - cdb_valid = 0, cdb_entry = ENTRY_NULL, cdb_value/cdb_pc/cdb_src = 0.
  - A reset asserted mid-operation discards all queued results.
- req_ready[i] = !full[i] && rdy_in && !roll_back.
  - full is computed from the registered count only; a pop in the same cycle does not free a slot.
- Push: req_valid[i] && req_ready[i] at a rising edge stores {entry, value, pc} at the tail.
  - A request with entry == ENTRY_NULL is accepted (handshake completes) but never stored or broadcast.
- Arbitration: combinational over FIFO heads. Starting at rr_ptr, the first non-empty source wins.
- At each edge with rdy_in high and no roll_back:
  - winner exists: pop its head; cdb_* <= head fields; cdb_src <= winner; cdb_valid <= 1; rr_ptr <= (winner+1) mod NUM_SRC.
  - no winner: cdb_valid <= 0; other cdb_* fields hold; rr_ptr holds.
- Latency: request presented in cycle t (accepted at end of t) gives cdb_valid in cycle t+2 if uncontended. There is no bypass path.
- cdb_valid is high for exactly one cycle per result unless rdy_in is low.
- Fairness: a non-empty source is granted within NUM_SRC cycles. Per-source order is FIFO; no loss, no duplication.
- Throughput: one broadcast per cycle total.
- rdy_in low: no push, no pop. All registers, including cdb_valid, hold their values. Consumers are paused too, so the held strobe is not re-consumed.
- roll_back high at an edge (takes precedence over rdy_in):
  - all FIFOs emptied; cdb_valid <= 0; rr_ptr <= 0.
  - same-cycle requests are dropped (req_ready is low).
- Simultaneous push and pop on the same FIFO when not full: both occur; count unchanged.
- Pointers wrap modulo FIFO_DEPTH. Count width is clog2(FIFO_DEPTH)+1.

Decomposition:
- Shared package/constants file (existing operaType.v):
  - ENTRY_RANGE, ENTRY_NULL, TRUE/FALSE.
  - new CDB source indices SRC_ALU=0, SRC_LSB=1.
- One sub-module, cdb_src_fifo (parameter DEPTH and payload width):
  - push, pop and flush inputs; head, empty and full outputs.
  - instantiated NUM_SRC times.
- The arbiter and output register live in cdb_arbiter.

Test Plan:
1. Single request: ALU entry 5, value 0x00001234, pc 0x100, valid in cycle t.
   - Expect cdb_valid in t+2 with entry 5, value 0x1234, pc 0x100, src 0.
   - Expect cdb_valid 0 in t+3.
2. Contention: ALU entry 3 and LSB entry 7 in the same cycle t, rr_ptr = 0.
   - Expect ALU/3 in t+2, then LSB/7 in t+3.
   - Then a new simultaneous pair gives ALU first again (rr_ptr = 0).
3. Saturation: both sources valid every cycle with incrementing tags for 20 cycles.
   - Expect grants to alternate ALU/LSB.
   - Expect each FIFO to reach 2 and req_ready to drop.
   - Expect per-source tags in order, none lost or duplicated, 1 broadcast per cycle.
4. Flush: 2 ALU and 1 LSB results queued, roll_back pulsed 1 cycle.
   - Expect cdb_valid 0 the next cycle, the queued tags never broadcast, req_ready all 1 after.
5. Pause and reset:
   - rdy_in low 3 cycles while cdb_valid = 1 with entry 9: outputs frozen, req_ready 0, queue resumes in order.
   - Then rst_in low asynchronously mid-queue: cdb_valid 0 immediately, cdb_entry ENTRY_NULL, queues empty after release.
6. Null tag: LSB request with entry ENTRY_NULL.
   - Expect req_ready 1 and the handshake to complete.
   - Expect no cdb_valid from that request, with a following ALU request unaffected.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// Shared constants for the CDB arbiter slice: ROB tag sizing, null tag and source indices.
package cdb_arbiter_pkg;

  localparam int unsigned ENTRY_W = 5;
  typedef logic [ENTRY_W-1:0] entry_t;
  localparam entry_t ENTRY_NULL = '0;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [0:0] {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-source result queue; flush empties it and wins over push/pop in the same cycle.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty  = (r_count == '0);
  assign full   = (r_count == CNT_W'(DEPTH));
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rd_ptr];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset; the count alone defines validity.
  always_ff @(posedge clk_in) begin
    if (w_push && !flush) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter sharing one registered CDB broadcast among NUM_SRC result queues.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 2,
  parameter int unsigned ENTRY_W    = cdb_arbiter_pkg::ENTRY_W,
  parameter int unsigned FIFO_DEPTH = 2,
  localparam int unsigned SRC_W     = clog2_min1(NUM_SRC)
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       rdy_in,
  input  logic                       roll_back,
  input  logic [NUM_SRC-1:0]         req_valid,
  output logic [NUM_SRC-1:0]         req_ready,
  input  logic [NUM_SRC*ENTRY_W-1:0] req_entry,
  input  logic [NUM_SRC*32-1:0]      req_value,
  input  logic [NUM_SRC*32-1:0]      req_pc,
  output logic                       cdb_valid,
  output logic [ENTRY_W-1:0]         cdb_entry,
  output logic [31:0]                cdb_value,
  output logic [31:0]                cdb_pc,
  output logic [SRC_W-1:0]           cdb_src
);

  localparam int unsigned PAY_W = ENTRY_W + 64;
  localparam logic [ENTRY_W-1:0] W_NULL = ENTRY_W'(ENTRY_NULL);

  logic [PAY_W-1:0]   w_head [NUM_SRC];
  logic [NUM_SRC-1:0] w_empty;
  logic [NUM_SRC-1:0] w_full;
  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_found;
  logic [SRC_W-1:0]   w_winner;
  logic [PAY_W-1:0]   w_win_head;

  logic               r_cdb_valid;
  logic [ENTRY_W-1:0] r_cdb_entry;
  logic [31:0]        r_cdb_value;
  logic [31:0]        r_cdb_pc;
  logic [SRC_W-1:0]   r_cdb_src;
  logic [SRC_W-1:0]   r_rr_ptr;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    logic [ENTRY_W-1:0] w_entry;
    assign w_entry      = req_entry[g*ENTRY_W +: ENTRY_W];
    assign req_ready[g] = !w_full[g] && rdy_in && !roll_back;
    // Null tags complete the handshake but are never queued.
    assign w_push[g]    = req_valid[g] && req_ready[g] && (w_entry != W_NULL);
    assign w_pop[g]     = rdy_in && !roll_back && w_found && (w_winner == SRC_W'(g));

    cdb_src_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (PAY_W)
    ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .flush  (roll_back),
      .push   (w_push[g]),
      .pop    (w_pop[g]),
      .din    ({w_entry, req_value[g*32 +: 32], req_pc[g*32 +: 32]}),
      .head   (w_head[g]),
      .empty  (w_empty[g]),
      .full   (w_full[g])
    );
  end

  always_comb begin
    int unsigned idx;
    idx      = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (32'(r_rr_ptr) + k) % NUM_SRC;
      if (!w_found && !w_empty[SRC_W'(idx)]) begin
        w_found  = 1'b1;
        w_winner = SRC_W'(idx);
      end
    end
  end

  assign w_win_head = w_head[w_winner];

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_cdb_valid <= 1'b0;
      r_cdb_entry <= W_NULL;
      r_cdb_value <= '0;
      r_cdb_pc    <= '0;
      r_cdb_src   <= '0;
      r_rr_ptr    <= '0;
    end else if (roll_back) begin
      r_cdb_valid <= 1'b0;
      r_rr_ptr    <= '0;
    end else if (rdy_in) begin
      if (w_found) begin
        r_cdb_valid <= 1'b1;
        {r_cdb_entry, r_cdb_value, r_cdb_pc} <= w_win_head;
        r_cdb_src   <= w_winner;
        r_rr_ptr    <= (w_winner == SRC_W'(NUM_SRC - 1)) ? '0 : w_winner + 1'b1;
      end else begin
        r_cdb_valid <= 1'b0;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_entry = r_cdb_entry;
  assign cdb_value = r_cdb_value;
  assign cdb_pc    = r_cdb_pc;
  assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed and random stimulus for cdb_arbiter against a queue-based reference model.
module tb_cdb_arbiter;

  localparam int DEPTH = 2;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b0;
  logic        roll_back = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [9:0]  req_entry = '0;
  logic [63:0] req_value = '0;
  logic [63:0] req_pc = '0;
  logic        cdb_valid;
  logic [4:0]  cdb_entry;
  logic [31:0] cdb_value;
  logic [31:0] cdb_pc;
  logic [0:0]  cdb_src;

  cdb_arbiter #(
    .NUM_SRC    (2),
    .ENTRY_W    (5),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .roll_back (roll_back),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_entry (req_entry),
    .req_value (req_value),
    .req_pc    (req_pc),
    .cdb_valid (cdb_valid),
    .cdb_entry (cdb_entry),
    .cdb_value (cdb_value),
    .cdb_pc    (cdb_pc),
    .cdb_src   (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  // Reference model: one queue of {entry, value, pc} per source plus the broadcast it implies.
  logic [68:0] mq0[$];
  logic [68:0] mq1[$];
  logic        e_valid = 1'b0;
  logic [4:0]  e_entry = '0;
  logic [31:0] e_value = '0;
  logic [31:0] e_pc = '0;
  int          e_src = 0;
  int          rr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq0.delete();
    mq1.delete();
    e_valid = 1'b0;
    e_entry = '0;
    e_value = '0;
    e_pc    = '0;
    e_src   = 0;
    rr      = 0;
  endtask

  task automatic check_cdb(input string tag);
    chk({tag, ".valid"}, 64'(cdb_valid), 64'(e_valid));
    chk({tag, ".entry"}, 64'(cdb_entry), 64'(e_entry));
    chk({tag, ".value"}, 64'(cdb_value), 64'(e_value));
    chk({tag, ".pc"}, 64'(cdb_pc), 64'(e_pc));
    chk({tag, ".src"}, 64'(cdb_src), 64'(e_src));
  endtask

  // One clock cycle: drive after a falling edge, check ready, update model, check after next fall.
  task automatic step(input logic [1:0] v, input logic [4:0] a_e, input logic [4:0] l_e,
                      input logic [31:0] a_v, input logic [31:0] l_v,
                      input logic [31:0] a_pc, input logic [31:0] l_pc,
                      input logic rdy, input logic rb, output logic [1:0] acc);
    logic [1:0]  r;
    logic [68:0] h;
    int          win;
    int          s;
    req_valid = v;
    req_entry = {l_e, a_e};
    req_value = {l_v, a_v};
    req_pc    = {l_pc, a_pc};
    rdy_in    = rdy;
    roll_back = rb;
    #1;
    r[0] = (mq0.size() < DEPTH) && rdy && !rb;
    r[1] = (mq1.size() < DEPTH) && rdy && !rb;
    chk("req_ready", 64'(req_ready), 64'(r));
    acc = v & r;
    if (rb) begin
      mq0.delete();
      mq1.delete();
      e_valid = 1'b0;
      rr = 0;
    end else if (rdy) begin
      win = -1;
      for (int k = 0; k < 2; k++) begin
        s = (rr + k) % 2;
        if (win < 0 && ((s == 0) ? mq0.size() : mq1.size()) > 0) win = s;
      end
      if (win >= 0) begin
        h = (win == 0) ? mq0.pop_front() : mq1.pop_front();
        {e_entry, e_value, e_pc} = h;
        e_valid = 1'b1;
        e_src = win;
        rr = (win + 1) % 2;
      end else begin
        e_valid = 1'b0;
      end
      if (acc[0] && a_e != 5'd0) mq0.push_back({a_e, a_v, a_pc});
      if (acc[1] && l_e != 5'd0) mq1.push_back({l_e, l_v, l_pc});
    end
    @(negedge clk_in);
    check_cdb("cdb");
  endtask

  task automatic idle(input int n);
    logic [1:0] acc;
    for (int i = 0; i < n; i++) step(2'b00, 5'd0, 5'd0, '0, '0, '0, '0, 1'b1, 1'b0, acc);
  endtask

  initial begin
    logic [1:0] acc;
    int         a_cnt;
    int         l_cnt;
    int         nvalid;
    int         saw_full;
    int         alt_bad;
    int         prev_src;

    // Reset state
    model_reset();
    #2;
    check_cdb("reset");
    chk("reset.ready", 64'(req_ready), 64'(0));
    @(negedge clk_in);
    rst_in = 1'b1;

    // 1: single ALU request, broadcast two cycles later
    step(2'b01, 5'd5, 5'd0, 32'h1234, 0, 32'h100, 0, 1'b1, 1'b0, acc);
    chk("t1.none_t1", 64'(cdb_valid), 64'(0));
    idle(1);
    chk("t1.entry", 64'({cdb_valid, cdb_entry, cdb_src}), 64'({1'b1, 5'd5, 1'b0}));
    chk("t1.value", 64'(cdb_value), 64'h1234);
    idle(1);
    chk("t1.off", 64'(cdb_valid), 64'(0));

    // 2: contention from rr_ptr = 0 (roll_back resets it)
    step(2'b00, 5'd0, 5'd0, 0, 0, 0, 0, 1'b1, 1'b1, acc);
    step(2'b11, 5'd3, 5'd7, 32'h33, 32'h77, 32'h300, 32'h700, 1'b1, 1'b0, acc);
    idle(1);
    chk("t2.first", 64'({cdb_entry, cdb_src}), 64'({5'd3, 1'b0}));
    idle(1);
    chk("t2.second", 64'({cdb_entry, cdb_src}), 64'({5'd7, 1'b1}));
    step(2'b11, 5'd4, 5'd8, 32'h44, 32'h88, 32'h400, 32'h800, 1'b1, 1'b0, acc);
    idle(1);
    chk("t2.again", 64'({cdb_entry, cdb_src}), 64'({5'd4, 1'b0}));
    idle(3);

    // 3: saturation, each source holds its tag until accepted
    a_cnt = 0; l_cnt = 0; nvalid = 0; saw_full = 0; alt_bad = 0; prev_src = -1;
    for (int c = 0; c < 20; c++) begin
      step(2'b11, 5'(1 + a_cnt % 15), 5'(16 + l_cnt % 15), 32'(a_cnt), 32'(l_cnt),
           32'h1000, 32'h2000, 1'b1, 1'b0, acc);
      if (acc != 2'b11) saw_full = 1;
      if (acc[0]) a_cnt++;
      if (acc[1]) l_cnt++;
      if (cdb_valid) begin
        nvalid++;
        if (prev_src >= 0 && int'(cdb_src) == prev_src) alt_bad++;
        prev_src = int'(cdb_src);
      end
    end
    chk("t3.broadcasts", 64'(nvalid), 64'(19));
    chk("t3.ready_dropped", 64'(saw_full), 64'(1));
    chk("t3.alternate", 64'(alt_bad), 64'(0));
    idle(5);

    // 4: flush with queued results
    step(2'b11, 5'd20, 5'd21, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    step(2'b11, 5'd22, 5'd23, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    step(2'b00, 5'd0, 5'd0, 0, 0, 0, 0, 1'b1, 1'b1, acc);
    chk("t4.flushed", 64'(cdb_valid), 64'(0));
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      if (cdb_valid) nvalid++;
    end
    chk("t4.no_stale", 64'(nvalid), 64'(0));
    #1;
    chk("t4.ready", 64'(req_ready), 64'(2'b11));

    // 5: pause while entry 9 is on the bus, then async reset mid-queue
    step(2'b01, 5'd9, 5'd0, 32'h9, 0, 0, 0, 1'b1, 1'b0, acc);
    step(2'b01, 5'd10, 5'd0, 32'hA, 0, 0, 0, 1'b1, 1'b0, acc);
    for (int c = 0; c < 3; c++) begin
      step(2'b01, 5'd11, 5'd0, 32'hB, 0, 0, 0, 1'b0, 1'b0, acc);
      chk("t5.frozen", 64'({cdb_valid, cdb_entry}), 64'({1'b1, 5'd9}));
    end
    step(2'b01, 5'd11, 5'd0, 32'hB, 0, 0, 0, 1'b1, 1'b0, acc);
    chk("t5.resume", 64'(cdb_entry), 64'(10));
    idle(1);
    chk("t5.order", 64'(cdb_entry), 64'(11));
    step(2'b11, 5'd12, 5'd13, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    step(2'b11, 5'd14, 5'd15, 0, 0, 0, 0, 1'b1, 1'b0, acc);
    #2;
    rst_in = 1'b0;
    #1;
    model_reset();
    check_cdb("t5.rst");
    @(negedge clk_in);
    rst_in = 1'b1;
    idle(3);

    // 6: null-tag LSB request is accepted but never broadcast
    step(2'b10, 5'd0, 5'd0, 0, 32'hDEAD, 0, 32'hBEEF, 1'b1, 1'b0, acc);
    chk("t6.accepted", 64'(acc), 64'(2'b10));
    step(2'b01, 5'd6, 5'd0, 32'h66, 0, 32'h600, 0, 1'b1, 1'b0, acc);
    nvalid = 0;
    for (int c = 0; c < 4; c++) begin
      idle(1);
      if (cdb_valid) begin
        nvalid++;
        chk("t6.alu", 64'({cdb_entry, cdb_src}), 64'({5'd6, 1'b0}));
      end
    end
    chk("t6.count", 64'(nvalid), 64'(1));

    // Random traffic with occasional pauses, flushes and null tags
    for (int c = 0; c < 400; c++) begin
      step(2'($urandom), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
           $urandom, $urandom, $urandom, $urandom,
           ($urandom_range(0, 7) != 0), ($urandom_range(0, 31) == 0), acc);
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
